// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//   Block-granular main data memory behind the data cache controller. Holds
//   2^ADDR_WIDTH blocks of DATA_WIDTH bits, one cache line each. Every request
//   occupies the memory for LATENCY ACCESS cycles, then one DONE cycle in
//   which busywait is low and readdata is valid. With CLEAR_ON_RESET set, a
//   zero-fill sweep runs after reset before any request is accepted.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   read       block read request (level, held until busywait low)
//   write      block write request (level, held until busywait low)
//   address    block address {tag, index}
//   writedata  block to write
//   readdata   registered read result; changes only on a completing read or reset
//   busywait   high while a request is pending or the init sweep runs
// ---------------------------------------------------------------------------
module block_data_memory #(
  parameter int LATENCY        = 4,
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_ptr;
  logic [LAT_W-1:0]        lat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    op_write;
  logic                    last_access;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign last_access = (state == ACCESS) && (lat_cnt == LAT_W'(LATENCY - 1));

  // Control state machine. Only the latched request registers feed the
  // array once ACCESS is entered; the live inputs are ignored until IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
      sweep_ptr <= '0;
      lat_cnt   <= '0;
      readdata  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_write  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == '1) state <= IDLE;
        end
        IDLE: begin
          if (read || write) begin
            addr_q   <= address;
            wdata_q  <= writedata;
            // Simultaneous read and write is taken as a write.
            op_write <= write;
            lat_cnt  <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (last_access) begin
            if (!op_write) readdata <= mem[addr_q];
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Single array write port shared by the zero-fill sweep and the commit of
  // a write request; reset suppresses both so an in-flight write is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    if (!reset) begin
      if (state == INIT) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_ptr;
        mem_wdata = '0;
      end else if (last_access && op_write) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // In IDLE busywait follows the request inputs directly so the requester
  // stalls in the very cycle it raises read or write.
  always_comb begin
    busywait = 1'b0;
    if (reset) begin
      busywait = (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        INIT:    busywait = 1'b1;
        IDLE:    busywait = read | write;
        ACCESS:  busywait = 1'b1;
        DONE:    busywait = 1'b0;
        default: busywait = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// ---------------------------------------------------------------------------
// tb_block_data_memory
//   Directed bench for block_data_memory. Instance a runs with the zero-fill
//   sweep enabled, instance b without it (used for the reset-abort case).
// ---------------------------------------------------------------------------
module tb_block_data_memory;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, read_a, write_a, busywait_a;
  logic [5:0]  address_a;
  logic [31:0] writedata_a, readdata_a;

  logic        reset_b, read_b, write_b, busywait_b;
  logic [5:0]  address_b;
  logic [31:0] writedata_b, readdata_b;

  int total = 0;
  int bad   = 0;

  block_data_memory #(
    .LATENCY(4), .ADDR_WIDTH(6), .DATA_WIDTH(32), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clock(clock), .reset(reset_a), .read(read_a), .write(write_a),
    .address(address_a), .writedata(writedata_a),
    .readdata(readdata_a), .busywait(busywait_a)
  );

  block_data_memory #(
    .LATENCY(4), .ADDR_WIDTH(6), .DATA_WIDTH(32), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .clock(clock), .reset(reset_b), .read(read_b), .write(write_b),
    .address(address_b), .writedata(writedata_b),
    .readdata(readdata_b), .busywait(busywait_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic rd, input logic wr,
                       input logic [5:0] a, input logic [31:0] d);
    if (b) begin
      read_b = rd; write_b = wr; address_b = a; writedata_b = d;
    end else begin
      read_a = rd; write_a = wr; address_a = a; writedata_a = d;
    end
  endtask

  // Called just after a rising edge with the memory idle. Holds the request
  // until busywait is seen low, captures readdata in that DONE cycle, then
  // releases the request just after the next rising edge.
  task automatic req(input bit b, input logic rd, input logic wr,
                     input logic [5:0] a, input logic [31:0] d, input bit scramble,
                     output int bw_hi, output logic [31:0] rdata);
    bit seen_low;
    bw_hi    = 0;
    seen_low = 0;
    rdata    = '0;
    drive(b, rd, wr, a, d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!(b ? busywait_b : busywait_a)) begin
        seen_low = 1;
        rdata    = b ? readdata_b : readdata_a;
        break;
      end
      bw_hi++;
      if (scramble && i == 0) begin
        @(posedge clock); #1;
        drive(b, rd, wr, 6'h00, 32'h0);
      end
    end
    check("req_completed", {31'b0, seen_low}, 32'd1);
    @(posedge clock); #1;
    drive(b, 1'b0, 1'b0, 6'h00, 32'h0);
  endtask

  // Dirty-miss sequence as a cache controller issues it: write the victim
  // back, then request the refill in the cycle right after the write's DONE.
  task automatic cache_dirty_miss(input logic [5:0] victim, input logic [31:0] victim_data,
                                  input logic [5:0] refill,
                                  output int wb_bw, output int rf_bw, output logic [31:0] rf_data);
    logic [31:0] unused;
    req(0, 1'b0, 1'b1, victim, victim_data, 0, wb_bw, unused);
    req(0, 1'b1, 1'b0, refill, 32'h0, 0, rf_bw, rf_data);
  endtask

  initial begin
    int          bw, bw2, n;
    logic [31:0] rd;

    reset_a = 1; reset_b = 1;
    drive(0, 0, 0, 6'h00, 32'h0);
    drive(1, 0, 0, 6'h00, 32'h0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("reset_busy_a", {31'b0, busywait_a}, 32'd1);
    check("reset_busy_b", {31'b0, busywait_b}, 32'd0);
    check("reset_rdata_a", readdata_a, 32'h0);
    check("reset_rdata_b", readdata_b, 32'h0);
    @(posedge clock); #1;
    reset_a = 0; reset_b = 0;

    // Zero-fill sweep length
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busywait_a) n++;
      else break;
    end
    check("init_cycles", n, 32'd64);
    @(posedge clock); #1;

    req(0, 1, 0, 6'h2A, 32'h0, 0, bw, rd);
    check("rd2A_bw", bw, 32'd5);
    check("rd2A_data", rd, 32'h0);

    req(0, 0, 1, 6'h15, 32'hDEADBEEF, 0, bw, rd);
    check("wr15_bw", bw, 32'd5);
    check("wr15_rdata_hold", rd, 32'h0);
    req(0, 1, 0, 6'h15, 32'h0, 0, bw, rd);
    check("rd15_bw", bw, 32'd5);
    check("rd15_data", rd, 32'hDEADBEEF);

    // Inputs scrambled to 00/0 during the ACCESS cycles
    req(0, 0, 1, 6'h07, 32'h12345678, 1, bw, rd);
    check("wr07_bw", bw, 32'd5);
    req(0, 1, 0, 6'h00, 32'h0, 0, bw, rd);
    check("rd00_data", rd, 32'h0);
    req(0, 1, 0, 6'h07, 32'h0, 0, bw, rd);
    check("rd07_data", rd, 32'h12345678);

    // Read and write together act as a write
    req(0, 1, 1, 6'h3F, 32'hA5A5A5A5, 0, bw, rd);
    check("rw3F_bw", bw, 32'd5);
    check("rw3F_rdata_hold", rd, 32'h12345678);
    req(0, 1, 0, 6'h3F, 32'h0, 0, bw, rd);
    check("rd3F_data", rd, 32'hA5A5A5A5);

    // Write-back then refill, back to back
    req(0, 0, 1, 6'h19, 32'hFEEDC0DE, 0, bw, rd);
    cache_dirty_miss(6'h09, 32'h09090909, 6'h19, bw, bw2, rd);
    check("wb09_bw", bw, 32'd5);
    check("rf19_bw", bw2, 32'd5);
    check("rf19_data", rd, 32'hFEEDC0DE);
    @(negedge clock);
    check("no_dup_req", {31'b0, busywait_a}, 32'd0);
    @(posedge clock); #1;
    req(0, 1, 0, 6'h09, 32'h0, 0, bw, rd);
    check("rd09_data", rd, 32'h09090909);

    // Instance b: reset in the 3rd ACCESS cycle of a write
    req(1, 0, 1, 6'h10, 32'h11111111, 0, bw, rd);
    check("b_wr10_bw", bw, 32'd5);
    req(1, 1, 0, 6'h10, 32'h0, 0, bw, rd);
    check("b_rd10_pre", rd, 32'h11111111);
    drive(1, 0, 1, 6'h10, 32'hCAFEF00D);
    @(negedge clock);
    check("b_abort_busy_req", {31'b0, busywait_b}, 32'd1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_b = 1;
    drive(1, 0, 0, 6'h00, 32'h0);
    @(negedge clock);
    check("b_busy_in_reset", {31'b0, busywait_b}, 32'd0);
    @(posedge clock); #1;
    reset_b = 0;
    @(negedge clock);
    check("b_busy_after_reset", {31'b0, busywait_b}, 32'd0);
    check("b_rdata_after_reset", readdata_b, 32'h0);
    @(posedge clock); #1;
    req(1, 1, 0, 6'h10, 32'h0, 0, bw, rd);
    check("b_rd10_bw", bw, 32'd5);
    check("b_rd10_post", rd, 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
